wb_stage: RTL and testbench

- Write-back stage of the pipelined core; consumes the memory stage's valid/ack output (valid, instr, data).
- Holds one instruction in a commit slot and decides whether it writes rd.
- Arbitrates the single register-file write port against the debug write port.
- Exposes a forwarding view of the pending write and maintains the 64-bit retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 39 +++
 rtl/wb_stage.sv | 92 +++++++++
 tb/tb_wb_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: opcode map, commit-slot layout
// and the rd-write decode.
package wb_stage_pkg;

  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        illegal;
  } wb_slot_t;

  function automatic bit writes_rd(input logic [6:0] opc);
    case (opc)
      LOAD, OP, OP_IMM, LUI, AUIPC, JAL, JALR: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  function automatic bit is_known(input logic [6:0] opc);
    case (opc)
      STORE, BRANCH, MISC_MEM, SYSTEM: return 1'b1;
      default:                         return writes_rd(opc);
    endcase
  endfunction

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: one-entry commit slot, shared RF write port arbitration
// against debug writes, forwarding view and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int INSTRET_W = 64,
  parameter bit DBG_PRIO  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn_i,
  input  logic                 halt_i,
  input  logic                 valid_i,
  output logic                 ack_o,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          data_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  input  logic                 dbg_we_i,
  input  logic [4:0]           dbg_addr_i,
  input  logic [31:0]          dbg_data_i,
  output logic                 dbg_ack_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_rd_o,
  output logic [31:0]          fwd_data_o,
  output logic                 retire_o,
  output logic                 illegal_o,
  output logic [INSTRET_W-1:0] instret_o
);

  wb_slot_t             slot;
  logic [INSTRET_W-1:0] instret;
  logic                 run, port_busy, dbg_go, commit, accept;
  logic [6:0]           opc;
  logic [4:0]           rd;
  logic                 unused_instr;

  assign opc          = instr_i[6:0];
  assign rd           = instr_i[11:7];
  assign unused_instr = ^instr_i[31:12];

  // Combinational outputs are gated by reset so the block is silent while held.
  assign run       = rstn_i & ~halt_i;
  assign port_busy = slot.valid & slot.wr;
  assign dbg_go    = run & dbg_we_i & (~port_busy | DBG_PRIO);
  assign commit    = run & slot.valid & (~slot.wr | ~dbg_we_i | ~DBG_PRIO);
  assign accept    = run & valid_i & (~slot.valid | commit);

  assign ack_o       = accept;
  assign dbg_ack_o   = dbg_go;
  assign retire_o    = commit & ~slot.illegal;
  assign illegal_o   = commit & slot.illegal;
  assign fwd_valid_o = port_busy;
  assign fwd_rd_o    = slot.rd;
  assign fwd_data_o  = slot.data;
  assign instret_o   = instret;

  // dbg_go and a writing commit are mutually exclusive by construction.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (dbg_go) begin
      rf_we_o    = |dbg_addr_i;
      rf_waddr_o = dbg_addr_i;
      rf_wdata_o = dbg_data_i;
    end else if (commit & slot.wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = slot.rd;
      rf_wdata_o = slot.data;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      slot    <= '0;
      instret <= '0;
    end else begin
      if (accept) begin
        slot.valid   <= 1'b1;
        slot.wr      <= writes_rd(opc) & (|rd);
        slot.rd      <= rd;
        slot.data    <= data_i;
        slot.illegal <= ~is_known(opc);
      end else if (commit) begin
        slot.valid <= 1'b0;
      end
      if (retire_o) instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed table, hand sequences for
// conflicts/halt/reset/wrap, then randomized traffic against a slot model.
module tb_wb_stage;

  logic        clk, rstn_i, halt_i, valid_i, dbg_we_i;
  logic [31:0] instr_i, data_i, dbg_data_i;
  logic [4:0]  dbg_addr_i;

  logic        ack0, we0, dack0, fv0, ret0, ill0;
  logic [4:0]  wa0, frd0;
  logic [31:0] wd0, fd0;
  logic [63:0] cnt0;

  logic        ack1, we1, dack1, fv1, ret1, ill1;
  logic [4:0]  wa1, frd1;
  logic [31:0] wd1, fd1;
  logic [2:0]  cnt1;

  int errors = 0;
  int checks = 0;

  wb_stage #(.INSTRET_W(64), .DBG_PRIO(1'b1)) dut (
    .clk(clk), .rstn_i(rstn_i), .halt_i(halt_i), .valid_i(valid_i), .ack_o(ack0),
    .instr_i(instr_i), .data_i(data_i), .rf_we_o(we0), .rf_waddr_o(wa0), .rf_wdata_o(wd0),
    .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i), .dbg_ack_o(dack0),
    .fwd_valid_o(fv0), .fwd_rd_o(frd0), .fwd_data_o(fd0), .retire_o(ret0),
    .illegal_o(ill0), .instret_o(cnt0));

  wb_stage #(.INSTRET_W(3), .DBG_PRIO(1'b0)) dut1 (
    .clk(clk), .rstn_i(rstn_i), .halt_i(halt_i), .valid_i(valid_i), .ack_o(ack1),
    .instr_i(instr_i), .data_i(data_i), .rf_we_o(we1), .rf_waddr_o(wa1), .rf_wdata_o(wd1),
    .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i), .dbg_ack_o(dack1),
    .fwd_valid_o(fv1), .fwd_rd_o(frd1), .fwd_data_o(fd1), .retire_o(ret1),
    .illegal_o(ill1), .instret_o(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd);
    return {20'h0, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; halt_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_data_i = 0;
    instr_i = 0; data_i = 0;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] data;
    logic        ack, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ret, ill;
    logic [63:0] cnt;
  } vec_t;

  // Behavioural slot model for the random phase.
  typedef struct { bit present, wr, ill; bit [4:0] rd; bit [31:0] data; } mslot_t;

  function automatic mslot_t decode(input bit [31:0] ins, input bit [31:0] d);
    mslot_t m;
    bit [6:0] op = ins[6:0];
    m.present = 1; m.rd = ins[11:7]; m.data = d; m.wr = 0; m.ill = 0;
    if (op inside {7'h03, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67}) m.wr = (m.rd != 0);
    else if (!(op inside {7'h23, 7'h63, 7'h0F, 7'h73})) m.ill = 1;
    return m;
  endfunction

  vec_t tbl[8];
  logic [6:0] ops[14];

  initial begin
    mslot_t ms;
    longint unsigned mcnt;
    idle();
    rstn_i = 0;
    valid_i = 1; dbg_we_i = 1; dbg_addr_i = 3; dbg_data_i = 32'hDEAD; instr_i = enc(7'h13, 1);
    #3;
    chk("rst_ack", ack0, 0);     chk("rst_we", we0, 0);    chk("rst_waddr", wa0, 0);
    chk("rst_dack", dack0, 0);   chk("rst_fwd", fv0, 0);   chk("rst_ret", ret0, 0);
    chk("rst_ill", ill0, 0);     chk("rst_cnt", cnt0, 0);
    #4;
    idle(); rstn_i = 1;
    tick();

    // Back-to-back ADDIs, STORE, BRANCH, rd=x0, unknown opcode.
    tbl[0] = '{1, enc(7'h13, 1), 32'h11, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, enc(7'h13, 2), 32'h22, 1, 1, 1, 32'h11, 1, 0, 0};
    tbl[2] = '{1, enc(7'h23, 3), 32'h33, 1, 1, 2, 32'h22, 1, 0, 1};
    tbl[3] = '{1, enc(7'h63, 4), 32'h44, 1, 0, 0, 0, 1, 0, 2};
    tbl[4] = '{1, enc(7'h13, 0), 32'h55, 1, 0, 0, 0, 1, 0, 3};
    tbl[5] = '{1, enc(7'h7F, 9), 32'h66, 1, 0, 0, 0, 1, 0, 4};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 5};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
    for (int i = 0; i < 8; i++) begin
      valid_i = tbl[i].valid; instr_i = tbl[i].instr; data_i = tbl[i].data;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i), ack0, tbl[i].ack);
      chk($sformatf("tbl%0d_we", i), we0, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_waddr", i), wa0, tbl[i].waddr);
        chk($sformatf("tbl%0d_wdata", i), wd0, tbl[i].wdata);
      end
      chk($sformatf("tbl%0d_ret", i), ret0, tbl[i].ret);
      chk($sformatf("tbl%0d_ill", i), ill0, tbl[i].ill);
      chk($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].cnt);
      tick();
    end

    // Debug conflict: dut holds ADD x5 (debug first), dut1 commits first.
    valid_i = 1; instr_i = enc(7'h33, 5); data_i = 32'hA5;
    tick();
    valid_i = 1; instr_i = enc(7'h23, 7); data_i = 0;
    dbg_we_i = 1; dbg_addr_i = 6; dbg_data_i = 32'h66;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("cf_ack", ack0, 0);     chk("cf_we", we0, 1);      chk("cf_waddr", wa0, 6);
      chk("cf_wdata", wd0, 32'h66); chk("cf_dack", dack0, 1); chk("cf_fv", fv0, 1);
      chk("cf_frd", frd0, 5);     chk("cf_ret", ret0, 0);
      chk("cf1_ack", ack1, 1);    chk("cf1_dack", dack1, c);
      chk("cf1_waddr", wa1, c == 0 ? 5 : 6);
      tick();
    end
    valid_i = 0; dbg_we_i = 0;
    @(negedge clk);
    chk("cf_commit_we", we0, 1);  chk("cf_commit_waddr", wa0, 5);
    chk("cf_commit_wdata", wd0, 32'hA5); chk("cf_commit_ret", ret0, 1);
    chk("cf_commit_fv", fv0, 1);  chk("cf_commit_frd", frd0, 5);
    tick();
    @(negedge clk);
    chk("cf_after_fv", fv0, 0);   chk("cf_after_cnt", cnt0, 6);

    // Halt with full slot.
    tick();
    valid_i = 1; instr_i = enc(7'h13, 3); data_i = 32'h33;
    tick();
    halt_i = 1; instr_i = enc(7'h13, 8); dbg_we_i = 1; dbg_addr_i = 9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("halt_ack", ack0, 0);   chk("halt_we", we0, 0);   chk("halt_ret", ret0, 0);
      chk("halt_dack", dack0, 0); chk("halt_fv", fv0, 1);   chk("halt_cnt", cnt0, 6);
      tick();
    end
    idle();
    @(negedge clk);
    chk("unhalt_we", we0, 1);     chk("unhalt_waddr", wa0, 3);
    chk("unhalt_wdata", wd0, 32'h33); chk("unhalt_ret", ret0, 1);
    tick();
    @(negedge clk);
    chk("unhalt_cnt", cnt0, 7);

    // Asynchronous reset while stalled with a full slot.
    tick();
    valid_i = 1; instr_i = enc(7'h13, 4); data_i = 32'h44;
    tick();
    halt_i = 1; dbg_we_i = 1; dbg_addr_i = 9; dbg_data_i = 1;
    #2 rstn_i = 0;
    #1;
    chk("ares_ack", ack0, 0);   chk("ares_we", we0, 0);    chk("ares_dack", dack0, 0);
    chk("ares_fv", fv0, 0);     chk("ares_frd", frd0, 0);  chk("ares_fd", fd0, 0);
    chk("ares_ret", ret0, 0);   chk("ares_cnt", cnt0, 0);  chk("ares_cnt1", cnt1, 0);
    @(negedge clk);
    idle();
    #1 rstn_i = 1;
    tick();

    // Counter wrap on the 3-bit instance; the 64-bit one keeps counting.
    for (int k = 0; k <= 10; k++) begin
      valid_i = (k < 9); instr_i = enc(7'h13, 1); data_i = k;
      @(negedge clk);
      chk($sformatf("wrap%0d_cnt1", k), cnt1, ((k > 0 ? k - 1 : 0) % 8));
      chk($sformatf("wrap%0d_cnt0", k), cnt0, (k > 0 ? k - 1 : 0));
      tick();
    end

    // Randomized traffic against the model (dut only).
    idle(); rstn_i = 0;
    @(negedge clk);
    rstn_i = 1;
    tick();
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73,
            7'h7F, 7'h00, 7'h5B};
    ms = '{default: 0};
    mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      bit needs, dgo, com, acc, ewe;
      bit [4:0] ea;
      bit [31:0] ed, r;
      r = $urandom();
      valid_i  = ($urandom_range(3) != 0);
      halt_i   = ($urandom_range(5) == 0);
      dbg_we_i = ($urandom_range(4) == 0);
      dbg_addr_i = 5'($urandom_range(31));
      dbg_data_i = $urandom();
      data_i   = $urandom();
      instr_i  = {r[31:12], 5'($urandom_range(31)), ops[$urandom_range(13)]};
      needs = ms.present && ms.wr;
      dgo = !halt_i && dbg_we_i;
      com = ms.present && !halt_i && !(needs && dbg_we_i);
      acc = valid_i && !halt_i && (!ms.present || com);
      ewe = 0; ea = 0; ed = 0;
      if (dgo) begin ewe = (dbg_addr_i != 0); ea = dbg_addr_i; ed = dbg_data_i; end
      else if (com && ms.wr) begin ewe = 1; ea = ms.rd; ed = ms.data; end
      @(negedge clk);
      chk("rnd_ack", ack0, acc);   chk("rnd_we", we0, ewe);   chk("rnd_dack", dack0, dgo);
      if (ewe) begin chk("rnd_waddr", wa0, ea); chk("rnd_wdata", wd0, ed); end
      chk("rnd_ret", ret0, com && !ms.ill);
      chk("rnd_ill", ill0, com && ms.ill);
      chk("rnd_fv", fv0, needs);
      if (needs) begin chk("rnd_frd", frd0, ms.rd); chk("rnd_fd", fd0, ms.data); end
      chk("rnd_cnt", cnt0, mcnt);
      if (com && !ms.ill) mcnt++;
      if (acc) ms = decode(instr_i, data_i);
      else if (com) ms.present = 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
